// File: rtl/ad9826_cfg_seq.sv
// ad9826_cfg_seq: shadow copy of the eight AD9826 registers and a frame sequencer feeding the serial shifter.
// Define AD9826_READBACK_EN to follow every write with a read frame and compare the returned data.
module ad9826_cfg_seq #(
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int AUTO_INIT      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_wr,
    input  logic [2:0]  reg_addr,
    input  logic [8:0]  reg_wdata,
    output logic [8:0]  reg_rdata,
    input  logic        start_all,
    input  logic        start_one,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_addr,
    output logic [15:0] cfg_word,
    output logic        cfg_toggle,
    input  logic        cfg_sload,
    input  logic [15:0] cfg_readback
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] LOAD    = 4'd1;
    localparam logic [3:0] REQ     = 4'd2;
    localparam logic [3:0] WAIT    = 4'd3;
    localparam logic [3:0] NEXT    = 4'd4;
    localparam logic [3:0] FINISH  = 4'd5;
`ifdef AD9826_READBACK_EN
    localparam logic [3:0] RB_REQ  = 4'd6;
    localparam logic [3:0] RB_WAIT = 4'd7;
    localparam logic [3:0] CHECK   = 4'd8;
`endif

    logic [3:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             all_q, all_d;
    logic [15:0]      word_q, word_d;
    logic             toggle_q, toggle_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [2:0]       err_addr_q, err_addr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             init_q, init_d;
    logic [7:0][8:0]  shadow_q, shadow_d;
    logic             sload_s1_q, sload_s2_q;
    logic             tmo_hit, abort;
    logic             unused_rb;
`ifdef AD9826_READBACK_EN
    logic [8:0]       exp_q, exp_d;
    assign unused_rb = ^cfg_readback[15:9];
`else
    assign unused_rb = ^cfg_readback;
`endif

    assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign reg_rdata  = shadow_q[reg_addr];
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_addr   = err_addr_q;
    assign cfg_word   = word_q;
    assign cfg_toggle = toggle_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        all_d      = all_q;
        word_d     = word_q;
        toggle_d   = toggle_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        err_addr_d = err_addr_q;
        tmo_d      = '0;
        init_d     = 1'b0;
        shadow_d   = shadow_q;
        abort      = 1'b0;
`ifdef AD9826_READBACK_EN
        exp_d      = exp_q;
`endif
        if (reg_wr) shadow_d[reg_addr] = reg_wdata;

        case (state_q)
            IDLE: begin
                if (start_all || init_q || start_one) begin
                    error_d    = 1'b0;
                    err_addr_d = 3'd0;
                    busy_d     = 1'b1;
                    state_d    = LOAD;
                    if (start_all || init_q) begin
                        idx_d = 3'd0;
                        all_d = 1'b1;
                    end else begin
                        idx_d = reg_addr;
                        all_d = 1'b0;
                    end
                end
            end
            LOAD: begin
                word_d   = {1'b0, idx_q, 3'b000, shadow_q[idx_q]};
`ifdef AD9826_READBACK_EN
                exp_d    = shadow_q[idx_q];
`endif
                toggle_d = 1'b1;
                state_d  = REQ;
            end
            REQ: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (!sload_s2_q) begin
                    toggle_d = 1'b0;
                    state_d  = WAIT;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (sload_s2_q) begin
`ifdef AD9826_READBACK_EN
                    word_d   = {1'b1, idx_q, 12'h000};
                    toggle_d = 1'b1;
                    state_d  = RB_REQ;
`else
                    state_d  = NEXT;
`endif
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
`ifdef AD9826_READBACK_EN
            RB_REQ: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (!sload_s2_q) begin
                    toggle_d = 1'b0;
                    state_d  = RB_WAIT;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            RB_WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (sload_s2_q) state_d = CHECK;
                else if (tmo_hit) abort = 1'b1;
            end
            CHECK: begin
                if (cfg_readback[8:0] != exp_q) begin
                    error_d    = 1'b1;
                    err_addr_d = idx_q;
                    state_d    = FINISH;
                end else begin
                    state_d    = NEXT;
                end
            end
`endif
            NEXT: begin
                if (all_q && idx_q != 3'd7) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = LOAD;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // a stuck handshake drops the request and still closes the sequence with done
        if (abort) begin
            error_d    = 1'b1;
            err_addr_d = idx_q;
            toggle_d   = 1'b0;
            state_d    = FINISH;
        end
        if (state_d != state_q) tmo_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            all_q       <= 1'b0;
            word_q      <= 16'h0000;
            toggle_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_addr_q  <= 3'd0;
            tmo_q       <= '0;
            init_q      <= (AUTO_INIT != 0);
            shadow_q    <= '0;
            shadow_q[0] <= 9'h0C8;
            shadow_q[1] <= 9'h0C0;
            sload_s1_q  <= 1'b1;
            sload_s2_q  <= 1'b1;
`ifdef AD9826_READBACK_EN
            exp_q       <= 9'h000;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            all_q       <= all_d;
            word_q      <= word_d;
            toggle_q    <= toggle_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_addr_q  <= err_addr_d;
            tmo_q       <= tmo_d;
            init_q      <= init_d;
            shadow_q    <= shadow_d;
            sload_s1_q  <= cfg_sload;
            sload_s2_q  <= sload_s1_q;
`ifdef AD9826_READBACK_EN
            exp_q       <= exp_d;
`endif
        end
    end
endmodule
